acs_sched: RTL and testbench

- Time-multiplexed scheduler for the Viterbi BMC/ACS datapath.
- Accepts one received symbol pair per trellis step.
- Sweeps all trellis states through a bank of NUM_ACS parallel BMC/ACS units, one state group per cycle.
- Sequences the ping-pong path-metric (PM) banks, survivor writes, metric normalization and the traceback start trigger.
- Sits between the demapper output and the BMC/ACS bank / survivor memory.

---
 rtl/acs_sched.sv | 157 +++++++++++++++
 tb/tb_acs_sched.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acs_sched.sv
// acs_sched: sweeps trellis state groups through the BMC/ACS bank, one symbol per step.
// Optional metric normalization is built when ACS_SCHED_NORM_EN is defined.
module acs_sched #(
    parameter int unsigned NUM_STATES  = 64,
    parameter int unsigned NUM_ACS     = 8,
    parameter int unsigned ACS_LAT     = 2,
    parameter int unsigned PM_W        = 8,
    parameter int unsigned NORM_THRESH = 128,
    parameter int unsigned TB_DEPTH    = 32,
    localparam int unsigned G  = NUM_STATES / NUM_ACS,
    localparam int unsigned GW = (G > 1) ? $clog2(G) : 1,
    localparam int unsigned TW = (TB_DEPTH > 1) ? $clog2(TB_DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sym_valid,
    output logic             sym_ready,
    input  logic [1:0]       sym_pair,
    output logic             acs_en,
    output logic [1:0]       acs_pair,
    output logic [GW-1:0]    grp_idx,
    output logic             pm_rd_bank,
    output logic             pm_wr_en,
    output logic [GW-1:0]    pm_wr_grp,
    input  logic [PM_W-1:0]  acs_min,
    output logic             norm_en,
    output logic [PM_W-1:0]  norm_val,
    output logic             surv_wr_en,
    output logic [TW+GW-1:0] surv_wr_addr,
    output logic             tb_start,
    output logic             busy
);

    localparam int unsigned CW = $clog2(ACS_LAT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   drain_cnt;
    logic [TW-1:0]   step_ptr;
    logic [TW:0]     fill;
    logic [ACS_LAT-1:0] wr_en_pipe;
    logic [GW-1:0]   wr_grp_pipe [ACS_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sym_ready  <= 1'b1;
            busy       <= 1'b0;
            acs_en     <= 1'b0;
            acs_pair   <= '0;
            grp_idx    <= '0;
            drain_cnt  <= '0;
            pm_rd_bank <= 1'b0;
            step_ptr   <= '0;
            fill       <= '0;
            tb_start   <= 1'b0;
        end else begin
            tb_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (sym_valid) begin
                        acs_pair  <= sym_pair;
                        grp_idx   <= '0;
                        acs_en    <= 1'b1;
                        sym_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (grp_idx == GW'(G - 1)) begin
                        acs_en    <= 1'b0;
                        grp_idx   <= '0;
                        drain_cnt <= CW'(ACS_LAT - 1);
                        state     <= DRAIN;
                    end else begin
                        grp_idx <= grp_idx + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        // fill only changes on leaving DONE, so this is the pre-increment value
                        tb_start <= (fill >= (TW + 1)'(TB_DEPTH - 1));
                        state    <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                DONE: begin
                    pm_rd_bank <= ~pm_rd_bank;
                    step_ptr   <= step_ptr + 1'b1;
                    if (fill != (TW + 1)'(TB_DEPTH))
                        fill <= fill + 1'b1;
                    sym_ready  <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_pipe <= '0;
            for (int unsigned i = 0; i < ACS_LAT; i++)
                wr_grp_pipe[i] <= '0;
        end else begin
            wr_en_pipe[0]  <= acs_en;
            wr_grp_pipe[0] <= grp_idx;
            for (int unsigned i = 1; i < ACS_LAT; i++) begin
                wr_en_pipe[i]  <= wr_en_pipe[i-1];
                wr_grp_pipe[i] <= wr_grp_pipe[i-1];
            end
        end
    end

    assign pm_wr_en     = wr_en_pipe[ACS_LAT-1];
    assign pm_wr_grp    = wr_grp_pipe[ACS_LAT-1];
    assign surv_wr_en   = pm_wr_en;
    assign surv_wr_addr = {step_ptr, pm_wr_grp};

`ifdef ACS_SCHED_NORM_EN
    logic [PM_W-1:0] run_min;

    always_ff @(posedge clk) begin
        if (rst) begin
            run_min  <= '1;
            norm_en  <= 1'b0;
            norm_val <= '0;
        end else begin
            if (state == IDLE && sym_valid)
                run_min <= '1;
            else if (pm_wr_en && acs_min < run_min)
                run_min <= acs_min;
            // decision taken once per step, held for the whole next step
            if (state == DONE) begin
                if (run_min >= PM_W'(NORM_THRESH)) begin
                    norm_en  <= 1'b1;
                    norm_val <= run_min;
                end else begin
                    norm_en  <= 1'b0;
                    norm_val <= '0;
                end
            end
        end
    end
`else
    logic unused_acs_min;

    assign norm_en        = 1'b0;
    assign norm_val       = '0;
    assign unused_acs_min = ^acs_min;
`endif

endmodule

// File: tb/tb_acs_sched.sv
// Randomized bench for acs_sched against a step-level behavioural model.
// Normalization expectations follow ACS_SCHED_NORM_EN when it is defined.
module tb_acs_sched;

    localparam int unsigned NUM_STATES  = 64;
    localparam int unsigned NUM_ACS     = 8;
    localparam int unsigned L           = 2;
    localparam int unsigned PM_W        = 8;
    localparam int unsigned NORM_THRESH = 128;
    localparam int unsigned TB_DEPTH    = 32;
    localparam int unsigned G           = NUM_STATES / NUM_ACS;
    localparam int unsigned GW          = $clog2(G);
    localparam int unsigned TW          = $clog2(TB_DEPTH);
    localparam int          STEP_CYC    = G + L + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             sym_valid;
    logic             sym_ready;
    logic [1:0]       sym_pair;
    logic             acs_en;
    logic [1:0]       acs_pair;
    logic [GW-1:0]    grp_idx;
    logic             pm_rd_bank;
    logic             pm_wr_en;
    logic [GW-1:0]    pm_wr_grp;
    logic [PM_W-1:0]  acs_min;
    logic             norm_en;
    logic [PM_W-1:0]  norm_val;
    logic             surv_wr_en;
    logic [TW+GW-1:0] surv_wr_addr;
    logic             tb_start;
    logic             busy;

    int checks = 0;
    int errors = 0;

    acs_sched #(
        .NUM_STATES (NUM_STATES),
        .NUM_ACS    (NUM_ACS),
        .ACS_LAT    (L),
        .PM_W       (PM_W),
        .NORM_THRESH(NORM_THRESH),
        .TB_DEPTH   (TB_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sym_valid   (sym_valid),
        .sym_ready   (sym_ready),
        .sym_pair    (sym_pair),
        .acs_en      (acs_en),
        .acs_pair    (acs_pair),
        .grp_idx     (grp_idx),
        .pm_rd_bank  (pm_rd_bank),
        .pm_wr_en    (pm_wr_en),
        .pm_wr_grp   (pm_wr_grp),
        .acs_min     (acs_min),
        .norm_en     (norm_en),
        .norm_val    (norm_val),
        .surv_wr_en  (surv_wr_en),
        .surv_wr_addr(surv_wr_addr),
        .tb_start    (tb_start),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_k is the cycle position within a step (0 = waiting for a symbol).
    int m_k = 0, m_pair = 0, m_bank = 0, m_step = 0, m_fill = 0;
    int m_runmin = 255, m_norm_en = 0, m_norm_val = 0;

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            m_k = 0; m_pair = 0; m_bank = 0; m_step = 0; m_fill = 0;
            m_norm_en = 0; m_norm_val = 0; m_runmin = (1 << PM_W) - 1;
        end else if (m_k == 0) begin
            if (sym_valid === 1'b1) begin
                m_k = 1;
                m_pair = int'(sym_pair);
                m_runmin = (1 << PM_W) - 1;
            end
        end else begin
            if (m_k >= 1 + L && m_k <= G + L && int'(acs_min) < m_runmin)
                m_runmin = int'(acs_min);
            if (m_k == STEP_CYC - 1) begin
                m_bank = 1 - m_bank;
                m_step = (m_step + 1) % TB_DEPTH;
                if (m_fill < TB_DEPTH) m_fill++;
`ifdef ACS_SCHED_NORM_EN
                if (m_runmin >= NORM_THRESH) begin
                    m_norm_en = 1; m_norm_val = m_runmin;
                end else begin
                    m_norm_en = 0; m_norm_val = 0;
                end
`endif
                m_k = 0;
            end else begin
                m_k++;
            end
        end
    end

    bit chk_on = 0;
    int dir_mode = 0;
    int cnt_acs = 0, cnt_wr = 0, cnt_tb = 0, cnt_acc = 0;
    int wr_addr_at_grp0 = -1;
    bit e_acs, e_wr;
    logic [7:0] tbl1 [8] = '{8'd200, 8'd150, 8'd130, 8'd190, 8'd210, 8'd250, 8'd140, 8'd180};
    logic [7:0] tbl2 [8] = '{8'd220, 8'd100, 8'd101, 8'd255, 8'd180, 8'd100, 8'd140, 8'd199};

    always @(negedge clk) begin
        if (chk_on) begin
            e_acs = (m_k >= 1 && m_k <= G);
            e_wr  = (m_k >= 1 + L && m_k <= G + L);
            chk("busy", busy, m_k != 0);
            chk("sym_ready", sym_ready, m_k == 0);
            chk("acs_en", acs_en, e_acs);
            chk("acs_pair", acs_pair, m_pair);
            if (e_acs) chk("grp_idx", grp_idx, m_k - 1);
            chk("pm_wr_en", pm_wr_en, e_wr);
            chk("surv_wr_en", surv_wr_en, e_wr);
            if (e_wr) begin
                chk("pm_wr_grp", pm_wr_grp, m_k - 1 - L);
                chk("surv_wr_addr", surv_wr_addr, m_step * G + m_k - 1 - L);
            end
            chk("pm_rd_bank", pm_rd_bank, m_bank);
            chk("tb_start", tb_start, (m_k == STEP_CYC - 1) && (m_fill >= TB_DEPTH - 1));
            chk("norm_en", norm_en, m_norm_en);
            chk("norm_val", norm_val, m_norm_val);

            if (acs_en === 1'b1) cnt_acs++;
            if (acs_en === 1'b1 && grp_idx == 0) cnt_acc++;
            if (pm_wr_en === 1'b1) cnt_wr++;
            if (tb_start === 1'b1) cnt_tb++;
            if (pm_wr_en === 1'b1 && pm_wr_grp == 0) wr_addr_at_grp0 = int'(surv_wr_addr);
        end
        // acs_min for the write expected in the coming cycle
        if (e_wr && dir_mode == 1)      acs_min = tbl1[m_k - 1 - L];
        else if (e_wr && dir_mode == 2) acs_min = tbl2[m_k - 1 - L];
        else if ($urandom_range(0, 7) == 0) acs_min = PM_W'($urandom);
        else acs_min = PM_W'($urandom_range(100, 255));
    end

    // Accept in IDLE, then run the step to completion; returns #1 after the IDLE edge.
    task automatic do_step(input logic [1:0] pair);
        sym_valid = 1'b1;
        sym_pair  = pair;
        @(posedge clk); #1;
        sym_valid = 1'b0;
        sym_pair  = 2'($urandom);
        repeat (STEP_CYC - 1) @(posedge clk);
        #1;
    endtask

    int a0, w0, t0;

    initial begin
        rst = 1'b1; sym_valid = 1'b0; sym_pair = 2'b00;
        @(posedge clk); #1 chk_on = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_sym_ready", sym_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_bank", pm_rd_bank, 0);
        rst = 1'b0;

        // single symbol
        a0 = cnt_acs; w0 = cnt_wr;
        do_step(2'b10);
        chk("step1_acs_cycles", cnt_acs - a0, 8);
        chk("step1_wr_cycles", cnt_wr - w0, 8);
        chk("step1_bank", pm_rd_bank, 1);
        chk("step1_ready", sym_ready, 1);
        chk("step1_pair", acs_pair, 2'b10);
        chk("step1_addr_grp0", wr_addr_at_grp0, 0);

        // back-to-back: 39 more steps with valid held high
        a0 = cnt_acc; t0 = cnt_tb;
        sym_valid = 1'b1;
        repeat (38 * STEP_CYC + 1) begin
            @(posedge clk); #1;
            sym_pair = 2'($urandom);
        end
        sym_valid = 1'b0;
        repeat (STEP_CYC - 1) @(posedge clk);
        #1;
        chk("b2b_accepts", cnt_acc - a0, 39);
        chk("b2b_tb_pulses", cnt_tb - t0, 9);
        chk("b2b_bank", pm_rd_bank, 0);
        chk("b2b_last_addr", wr_addr_at_grp0, 56);
        chk("model_fill", m_fill, 32);
        chk("model_step", m_step, 8);

        // normalization
        dir_mode = 1;
        do_step(2'b01);
`ifdef ACS_SCHED_NORM_EN
        chk("norm_min130_en", norm_en, 1);
        chk("norm_min130_val", norm_val, 130);
`else
        chk("norm_off_en", norm_en, 0);
        chk("norm_off_val", norm_val, 0);
`endif
        dir_mode = 2;
        do_step(2'b11);
        chk("norm_min100_en", norm_en, 0);
        chk("norm_min100_val", norm_val, 0);
        dir_mode = 0;

        // reset during DRAIN
        sym_valid = 1'b1; sym_pair = 2'b11;
        @(posedge clk); #1 sym_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("rst_drain_busy", busy, 0);
        chk("rst_drain_ready", sym_ready, 1);
        chk("rst_drain_bank", pm_rd_bank, 0);
        chk("rst_drain_wr", pm_wr_en, 0);
        w0 = cnt_wr;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_drain_no_wr", cnt_wr - w0, 0);
        do_step(2'b00);
        chk("rst_drain_next_addr", wr_addr_at_grp0, 0);

        // reset and valid together
        rst = 1'b1; sym_valid = 1'b1;
        @(posedge clk); #1 rst = 1'b0; sym_valid = 1'b0;
        chk("rst_valid_busy", busy, 0);
        @(posedge clk); #1;
        chk("rst_valid_busy2", busy, 0);

        // random traffic with occasional resets
        repeat (900) begin
            rst       = ($urandom_range(0, 199) == 0);
            sym_valid = ($urandom_range(0, 2) != 0);
            sym_pair  = 2'($urandom);
            @(posedge clk); #1;
        end
        rst = 1'b0; sym_valid = 1'b0;
        repeat (STEP_CYC) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
